// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect
//   Monitors the dpll stage from the master clock domain. Rising edges of the
//   reference clock (clk_fin) and the recovered clock (clk_fout) are compared
//   to produce a signed phase error per reference cycle. A debounced lock
//   indicator and a loss-of-reference flag are derived from that error.
//
// Handshake: phase_valid is a one-cycle pulse with no back-pressure. phase_err
//   is updated in the same cycle as the pulse and holds its value between
//   pulses. Consumers must sample phase_err while phase_valid is high.
//
// Ports
//   clk          master clock (dpll clock)
//   reset        synchronous, active-high reset
//   clk_fin      reference clock, asynchronous to clk
//   clk_fout     dpll output clock, synchronous to clk
//   phase_err    signed error: +N means fout rose N clk after fin, -N means fout led
//   phase_valid  one-cycle pulse marking a new phase_err
//   locked       debounced lock status
//   fin_lost     no reference edge for 2*MAX_ERR+1 clk cycles
//   phase_state  debug view of the phase FSM (0 IDLE, 1 WAIT_FOUT, 2 WAIT_FIN)
//   lock_state   debug view of the lock FSM  (0 UNLOCKED, 1 LOCKING, 2 LOCKED)
module dpll_lock_detect #(
    parameter int ERR_W        = 9,
    parameter int WINDOW       = 8,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_fin,
    input  logic               clk_fout,
    output logic signed [ERR_W:0] phase_err,
    output logic               phase_valid,
    output logic               locked,
    output logic               fin_lost,
    output logic [1:0]         phase_state,
    output logic [1:0]         lock_state
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    localparam logic [ERR_W-1:0]        CNT_MAX     = '1;
    localparam logic [ERR_W:0]          GAP_LOST    = '1;  // 2*MAX_ERR+1
    localparam logic signed [ERR_W:0]   ERR_POS_MAX = {1'b0, CNT_MAX};
    localparam logic signed [ERR_W:0]   ERR_NEG_MAX = -ERR_POS_MAX;
    localparam logic [ERR_W:0]          WIN         = (ERR_W+1)'(WINDOW);
    localparam logic [GW-1:0]           LOCK_LAST   = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]           UNLOCK_LAST = BW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FOUT = 2'd1, WAIT_FIN = 2'd2} phase_state_t;
    typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} lock_state_t;

    // Alignment: two flops on each input so both paths see equal latency,
    // then one more flop for rising-edge detection.
    logic fin_s1, fin_s2, fin_d;
    logic fout_s1, fout_s2, fout_d;
    logic fin_rise, fout_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            fin_s1  <= 1'b0;
            fin_s2  <= 1'b0;
            fin_d   <= 1'b0;
            fout_s1 <= 1'b0;
            fout_s2 <= 1'b0;
            fout_d  <= 1'b0;
        end else begin
            fin_s1  <= clk_fin;
            fin_s2  <= fin_s1;
            fin_d   <= fin_s2;
            fout_s1 <= clk_fout;
            fout_s2 <= fout_s1;
            fout_d  <= fout_s2;
        end
    end

    assign fin_rise  = fin_s2 & ~fin_d;
    assign fout_rise = fout_s2 & ~fout_d;

    // Watchdog on the reference. lost_hit is the single cycle in which the
    // gap counter reaches its terminal value; it resets both FSMs.
    logic [ERR_W:0] fin_gap;
    logic           lost_hit;

    assign lost_hit = ~fin_rise && (fin_gap == GAP_LOST - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fin_gap  <= '0;
            fin_lost <= 1'b0;
        end else begin
            if (fin_rise)
                fin_gap <= '0;
            else if (fin_gap != GAP_LOST)
                fin_gap <= fin_gap + 1'b1;

            if (fin_rise)
                fin_lost <= 1'b0;
            else if (lost_hit)
                fin_lost <= 1'b1;
        end
    end

    // Phase FSM: whichever edge arrives first while idle starts the count;
    // the other edge closes it. A repeat of the starting edge means the other
    // clock missed a whole cycle and is reported as a saturated error.
    phase_state_t   ps;
    logic [ERR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps          <= IDLE;
            cnt         <= '0;
            phase_err   <= '0;
            phase_valid <= 1'b0;
        end else begin
            phase_valid <= 1'b0;
            if (lost_hit) begin
                ps  <= IDLE;
                cnt <= '0;
            end else begin
                case (ps)
                    IDLE: begin
                        if (fin_rise && fout_rise) begin
                            phase_err   <= '0;
                            phase_valid <= 1'b1;
                        end else if (fin_rise) begin
                            ps  <= WAIT_FOUT;
                            cnt <= ERR_W'(1);
                        end else if (fout_rise) begin
                            ps  <= WAIT_FIN;
                            cnt <= ERR_W'(1);
                        end
                    end
                    WAIT_FOUT: begin
                        if (fout_rise) begin
                            phase_err   <= signed'({1'b0, cnt});
                            phase_valid <= 1'b1;
                            ps          <= IDLE;
                        end else if (fin_rise) begin
                            phase_err   <= ERR_POS_MAX;
                            phase_valid <= 1'b1;
                            cnt         <= ERR_W'(1);
                        end else if (cnt == CNT_MAX) begin
                            phase_err   <= ERR_POS_MAX;
                            phase_valid <= 1'b1;
                            ps          <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_FIN: begin
                        if (fin_rise) begin
                            phase_err   <= -signed'({1'b0, cnt});
                            phase_valid <= 1'b1;
                            ps          <= IDLE;
                        end else if (fout_rise) begin
                            phase_err   <= ERR_NEG_MAX;
                            phase_valid <= 1'b1;
                            cnt         <= ERR_W'(1);
                        end else if (cnt == CNT_MAX) begin
                            phase_err   <= ERR_NEG_MAX;
                            phase_valid <= 1'b1;
                            ps          <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ps <= IDLE;
                endcase
            end
        end
    end

    assign phase_state = ps;

    // Sample classification on the registered error.
    logic [ERR_W:0] err_mag;
    logic           good_sample;

    assign err_mag     = phase_err[ERR_W] ? -phase_err : phase_err;
    assign good_sample = (err_mag <= WIN) && (err_mag != ERR_POS_MAX);

    // Lock FSM: consumes each phase_valid pulse the cycle after it appears.
    lock_state_t    ls;
    logic [GW-1:0]  good_cnt;
    logic [BW-1:0]  bad_cnt;

    always_ff @(posedge clk) begin
        if (reset || lost_hit) begin
            ls       <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else if (phase_valid) begin
            case (ls)
                UNLOCKED: begin
                    if (good_sample) begin
                        if (LOCK_COUNT == 1) begin
                            ls     <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            ls       <= LOCKING;
                            good_cnt <= GW'(1);
                        end
                    end
                end
                LOCKING: begin
                    if (!good_sample) begin
                        ls       <= UNLOCKED;
                        good_cnt <= '0;
                    end else if (good_cnt == LOCK_LAST) begin
                        ls       <= LOCKED;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else begin
                        good_cnt <= good_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (good_sample) begin
                        bad_cnt <= '0;
                    end else if (bad_cnt == UNLOCK_LAST) begin
                        ls      <= UNLOCKED;
                        locked  <= 1'b0;
                        bad_cnt <= '0;
                    end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                    end
                end
                default: begin
                    ls     <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign lock_state = ls;

endmodule

// File: tb/tb_dpll_lock_detect.sv
module tb_dpll_lock_detect;

  localparam int P = 256;

  logic              clk;
  logic              reset;
  logic              clk_fin;
  logic              clk_fout;
  logic signed [9:0] phase_err;
  logic              phase_valid;
  logic              locked;
  logic              fin_lost;
  logic [1:0]        phase_state;
  logic [1:0]        lock_state;

  logic [9:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  dpll_lock_detect dut (
    .clk(clk),
    .reset(reset),
    .clk_fin(clk_fin),
    .clk_fout(clk_fout),
    .phase_err(phase_err),
    .phase_valid(phase_valid),
    .locked(locked),
    .fin_lost(fin_lost),
    .phase_state(phase_state),
    .lock_state(lock_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every phase_valid pulse pops one expected error
  always @(negedge clk) begin
    if (phase_valid === 1'b1) begin
      logic [9:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: phase_err=%h, none expected", phase_err);
      end else begin
        exp_v = exp_q.pop_front();
        if (phase_err !== exp_v) begin
          errors++;
          $display("FAIL phase_err: got %h expected %h", phase_err, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic push_n(input int n, input int v);
    for (int i = 0; i < n; i++) exp_q.push_back(10'(v));
  endtask

  // periodic waveforms: fin delayed by df, fout delayed by dfo, both start low
  task automatic drive(input int periods, input int df, input int dfo, input bit fout_en, input int drain);
    int total;
    total = periods * P;
    for (int t = 0; t < total; t++) begin
      @(posedge clk); #1;
      clk_fin  = (t >= df) && (((t - df) % P) < P / 2);
      clk_fout = fout_en && (t >= dfo) && (((t - dfo) % P) < P / 2);
    end
    @(posedge clk); #1;
    clk_fin  = 1'b0;
    clk_fout = 1'b0;
    repeat (drain) @(posedge clk);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clk_fin = 1'b0;
    clk_fout = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({phase_err, phase_valid, locked, fin_lost, phase_state, lock_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: err=%h v=%b lk=%b lost=%b ps=%0d ls=%0d, all zero required",
               phase_err, phase_valid, locked, fin_lost, phase_state, lock_state);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_aligned_lock;
    push_n(15, 0);
    drive(15, 0, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_after_15: locked=%b expected 0", locked); end
    push_n(1, 0);
    drive(1, 0, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_16: locked=%b expected 1", locked); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL aligned_drain: %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_unlock_debounce;
    push_n(3, 20);
    drive(3, 0, 20, 1'b1, 10);
    push_n(1, 2);
    drive(1, 0, 2, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL hold_after_3bad_1good: locked=%b expected 1", locked); end
    push_n(3, 20);
    drive(3, 0, 20, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL hold_after_3bad: locked=%b expected 1", locked); end
    push_n(1, 20);
    drive(1, 0, 20, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL drop_after_4bad: locked=%b expected 0", locked); end
  endtask

  task automatic test_lag_lead;
    push_n(3, 5);
    drive(3, 0, 5, 1'b1, 10);
    for (int i = 0; i < 3; i++) exp_q.push_back(10'h3FB);
    drive(3, 5, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lag_lead_drain: %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_locking_restart;
    do_reset();
    push_n(15, 0);
    drive(15, 0, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (lock_state !== 2'd1) begin errors++; $display("FAIL locking_state: lock_state=%0d expected 1", lock_state); end
    push_n(1, 9);
    drive(1, 0, 9, 1'b1, 10);
    @(negedge clk);
    checks++;
    if ({locked, lock_state} !== 3'b000) begin
      errors++; $display("FAIL bad9_unlocks: locked=%b lock_state=%0d expected 0/0", locked, lock_state);
    end
    push_n(15, 8);
    drive(15, 0, 8, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL relock_after_15: locked=%b expected 0", locked); end
    push_n(1, 8);
    drive(1, 0, 8, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_after_16: locked=%b expected 1", locked); end
  endtask

  task automatic test_fout_stuck;
    do_reset();
    // 19 repeated-fin errors plus a final count timeout
    push_n(20, 511);
    drive(20, 0, 0, 1'b0, 600);
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL stuck_locked: locked=%b expected 0", locked); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stuck_drain: %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_fin_lost;
    push_n(16, 0);
    drive(16, 0, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL prelost_locked: locked=%b expected 1", locked); end
    repeat (700) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fin_lost !== 1'b0) begin errors++; $display("FAIL lost_early: fin_lost=%b expected 0", fin_lost); end
    repeat (150) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fin_lost, locked, lock_state} !== 4'b1000) begin
      errors++; $display("FAIL lost_set: fin_lost=%b locked=%b lock_state=%0d expected 1/0/0", fin_lost, locked, lock_state);
    end
    repeat (250) @(posedge clk);
    push_n(3, 0);
    drive(3, 0, 0, 1'b1, 10);
    @(negedge clk);
    checks++;
    if ({fin_lost, locked} !== 2'b00) begin
      errors++; $display("FAIL lost_recover: fin_lost=%b locked=%b expected 0/0", fin_lost, locked);
    end
  endtask

  task automatic test_reset_mid_measure;
    @(posedge clk); #1;
    clk_fin  = 1'b1;
    clk_fout = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (phase_state !== 2'd1) begin errors++; $display("FAIL wait_fout_entry: phase_state=%0d expected 1", phase_state); end
    @(posedge clk); #1;
    reset   = 1'b1;
    clk_fin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({phase_err, phase_valid, locked, fin_lost, phase_state, lock_state} !== '0) begin
      errors++;
      $display("FAIL mid_reset: err=%h v=%b lk=%b lost=%b ps=%0d ls=%0d, all zero required",
               phase_err, phase_valid, locked, fin_lost, phase_state, lock_state);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (phase_state !== 2'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL post_reset_idle: phase_state=%0d pending=%0d expected 0/0", phase_state, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_unlock_debounce();
    test_lag_lead();
    test_locking_restart();
    test_fout_stuck();
    test_fin_lost();
    test_reset_mid_measure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
